// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state encoding and counter-width helper for the PISO transmit path
package piso_serializer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: load/shift/hold word register presenting the current serial bit from a flop
module piso_shift_core #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);
  logic [WIDTH-1:0] data_q, data_d;
  // Zero fill means the register is empty once a full word has shifted out
  always_comb data_d = load ? d : shift ? (LSB_FIRST ? data_q >> 1 : data_q << 1) : data_q;
  always_ff @(posedge clk)
    if (!rst) data_q <= '0;
    else data_q <= data_d;
  assign sout = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in serial-out transmitter with framing strobes
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             tx_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             sout_last
);
  localparam int CW = cnt_w(WIDTH);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_q, frame_d, last_q, last_d;
  logic          adv, last_bit, accept;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  always_comb begin
    state_d = accept ? ST_SHIFT : last_bit ? ST_IDLE : state_q;
    cnt_d   = (accept || last_bit) ? '0 : adv ? cnt_q + CW'(1) : cnt_q;
    frame_d = accept ? 1'b1 : adv ? 1'b0 : frame_q;
    last_d  = accept ? 1'b0 : adv ? (cnt_q == CW'(WIDTH - 2)) : last_q;
  end
  always_comb begin
    adv        = (state_q == ST_SHIFT) && tx_en;
    last_bit   = adv && (cnt_q == CW'(WIDTH - 1));
    load_ready = rst && ((state_q == ST_IDLE) || last_bit);
    accept     = load_valid && load_ready;
  end
  piso_shift_core #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(adv),
    .d    (d),
    .sout (sout)
  );
  assign sout_valid  = (state_q == ST_SHIFT);
  assign frame_start = frame_q;
  assign sout_last   = last_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_piso_serializer;
  localparam int W = 4;
  typedef struct packed {logic b; logic f; logic l;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] d = '0;
  logic load_valid = 1'b0;
  logic tx_en = 1'b0;
  logic [1:0] lr, so, sv, fs, sl;
  ent_t q[2][$];
  int rem = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(lr[0]), .tx_en(tx_en),
    .sout(so[0]), .sout_valid(sv[0]), .frame_start(fs[0]), .sout_last(sl[0])
  );
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(lr[1]), .tx_en(tx_en),
    .sout(so[1]), .sout_valid(sv[1]), .frame_start(fs[1]), .sout_last(sl[1])
  );
  // Reference: a word occupies the line for W advancing cycles; the next may load as the last leaves
  always @(posedge clk) begin
    if (!rst) begin
      q[0].delete();
      q[1].delete();
      rem = 0;
    end else begin
      automatic logic ready = (rem == 0) || (rem == 1 && tx_en);
      if (rem > 0 && tx_en) rem--;
      if (load_valid && ready) begin
        for (int i = 0; i < W; i++) begin
          q[1].push_back('{b: d[i], f: i == 0, l: i == W - 1});
          q[0].push_back('{b: d[W-1-i], f: i == 0, l: i == W - 1});
        end
        rem = W;
      end
    end
  end
  task automatic chk(input string n, input int k, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s lane%0d got %b expected %b at %0t", n, k, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    automatic logic exp_lr = rst && ((rem == 0) || (rem == 1 && tx_en));
    for (int k = 0; k < 2; k++) begin
      chk("load_ready", k, lr[k], exp_lr);
      chk("sout_valid", k, sv[k], rem > 0);
      if (sv[k] === 1'b1) begin
        if (q[k].size() == 0) chk("queue_underflow", k, 1'b1, 1'b0);
        else begin
          chk("sout", k, so[k], q[k][0].b);
          chk("frame_start", k, fs[k], q[k][0].f);
          chk("sout_last", k, sl[k], q[k][0].l);
          if (tx_en) void'(q[k].pop_front());
        end
      end else begin
        chk("sout_idle", k, so[k], 1'b0);
        chk("frame_idle", k, fs[k], 1'b0);
        chk("last_idle", k, sl[k], 1'b0);
      end
    end
  end
  task automatic cyc(input logic r, input logic lv, input logic [W-1:0] dd, input logic te);
    rst = r;
    load_valid = lv;
    d = dd;
    tx_en = te;
    @(posedge clk);
    #2;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b1);
  endtask
  initial begin
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    idle(1);
    cyc(1'b1, 1'b1, 4'b1011, 1'b1);
    idle(6);
    cyc(1'b1, 1'b1, 4'hA, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 4'h5, 1'b1);
    idle(6);
    cyc(1'b1, 1'b1, 4'b0110, 1'b1);
    cyc(1'b1, 1'b0, 4'hF, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 4'hF, 1'b0);
    idle(5);
    cyc(1'b1, 1'b1, 4'hF, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 4'h1, 1'b1);
    idle(6);
    cyc(1'b1, 1'b1, 4'b1000, 1'b1);
    idle(6);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 39) != 0, 1'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    idle(8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
